// File: rtl/sram_responder_if.sv
// sram_responder_if: CPU-side sram-style port bundle.
//   sram_en     access request this cycle
//   sram_wen    byte-lane write enables (0 with en=1 is a read)
//   sram_addr   byte address, bits [1:0] ignored by the responder
//   sram_wdata  write data, lane i = bits [8i+7:8i]
//   sram_rdata  registered, held read data
//   rd_valid    pulse on the cycle sram_rdata takes a new read value
//   addr_err    pulse the cycle after an out-of-window request
// master = requester (CPU or bench), slave = memory responder.
interface sram_responder_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        rd_valid;
    logic        addr_err;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata,
        input  rd_valid,
        input  addr_err
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata,
        output rd_valid,
        output addr_err
    );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for an sram-style CPU port.
// Single-port word RAM with byte-lane writes, a READ_LAT-cycle read pipeline feeding a
// held read-data register, window (address range) checking and saturating access counters.
//
// Ports:
//   clk     clock, all logic on posedge
//   reset   synchronous reset, active-high (RAM contents are not reset)
//   bus     slave side of sram_responder_if (en/wen/addr/wdata in, rdata/rd_valid/addr_err out)
//   rd_cnt  accepted in-window reads, saturating
//   wr_cnt  accepted in-window writes, saturating
module sram_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'hbfc00000,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_responder_if.slave        bus,
    output logic [31:0]            rd_cnt,
    output logic [31:0]            wr_cnt
);
    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam int unsigned TagLsb = ADDR_WIDTH + 2;

    if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_lat
        $error("sram_responder: READ_LAT must be 1..3");
    end
    if (BASE_ADDR[TagLsb-1:0] != '0) begin : g_bad_base
        $error("sram_responder: BASE_ADDR not aligned to the window size");
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  hit;
    logic                  req_rd;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  unused_addr_lsb;

    assign hit      = (bus.sram_addr[31:TagLsb] == BASE_ADDR[31:TagLsb]);
    assign word_idx = bus.sram_addr[TagLsb-1:2];
    assign req_rd   = bus.sram_en && (bus.sram_wen == 4'b0000);
    assign req_wr   = bus.sram_en && (bus.sram_wen != 4'b0000);

    // Byte offset within the word has no meaning for a word RAM.
    assign unused_addr_lsb = ^bus.sram_addr[1:0];

    // ------------------------------------------------------------------
    // Word RAM (not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        // A write presented together with reset is dropped.
        if (!reset && req_wr && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_wen[i]) begin
                    mem_q[word_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // The word is sampled at the request edge, so a write on the following edge cannot
    // disturb a read already in flight, and a write on the previous edge is visible.
    logic [31:0] rd_word;
    assign rd_word = hit ? mem_q[word_idx] : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Read pipeline: READ_LAT-1 intermediate stages, the last stage being sram_rdata
    // ------------------------------------------------------------------
    logic [31:0] tap_data;
    logic        tap_valid;

    if (READ_LAT <= 1) begin : g_lat1
        assign tap_data  = rd_word;
        assign tap_valid = req_rd;
    end else begin : g_pipe
        localparam int PipeLen = int'(READ_LAT) - 1;

        logic [31:0] pipe_data_q  [PipeLen];
        logic        pipe_valid_q [PipeLen];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < PipeLen; k++) begin
                    pipe_data_q[k]  <= 32'h0000_0000;
                    pipe_valid_q[k] <= 1'b0;
                end
            end else begin
                pipe_data_q[0]  <= rd_word;
                pipe_valid_q[0] <= req_rd;
                for (int k = 1; k < PipeLen; k++) begin
                    pipe_data_q[k]  <= pipe_data_q[k-1];
                    pipe_valid_q[k] <= pipe_valid_q[k-1];
                end
            end
        end

        assign tap_data  = pipe_data_q[PipeLen-1];
        assign tap_valid = pipe_valid_q[PipeLen-1];
    end

    // ------------------------------------------------------------------
    // Held read data, valid and error pulses
    // ------------------------------------------------------------------
    logic [31:0] rdata_q;
    logic        rd_valid_q;
    logic        addr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= tap_valid;
            // Only a completing read may change rdata; the CPU re-reads it later.
            if (tap_valid) begin
                rdata_q <= tap_data;
            end
            addr_err_q <= bus.sram_en && !hit;
        end
    end

    assign bus.sram_rdata = rdata_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.addr_err   = addr_err_q;

    // ------------------------------------------------------------------
    // Saturating access counters
    // ------------------------------------------------------------------
    logic [31:0] rd_cnt_q;
    logic [31:0] rd_cnt_d;
    logic [31:0] wr_cnt_q;
    logic [31:0] wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (req_rd && hit && (rd_cnt_q != 32'hffff_ffff)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (req_wr && hit && (wr_cnt_q != 32'hffff_ffff)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 32'h0000_0000;
            wr_cnt_q <= 32'h0000_0000;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bench for sram_responder with READ_LAT = 1, 2 and 3 instances.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_sram_responder;
    logic clk;
    logic rst1;
    logic rst2;
    logic rst3;
    logic [31:0] rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2, rd_cnt3, wr_cnt3;
    int errors;
    int checks;

    sram_responder_if bus1 ();
    sram_responder_if bus2 ();
    sram_responder_if bus3 ();

    sram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'hbfc00000), .READ_LAT(1)) u_lat1 (
        .clk    (clk),
        .reset  (rst1),
        .bus    (bus1),
        .rd_cnt (rd_cnt1),
        .wr_cnt (wr_cnt1)
    );

    sram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'hbfc00000), .READ_LAT(2)) u_lat2 (
        .clk    (clk),
        .reset  (rst2),
        .bus    (bus2),
        .rd_cnt (rd_cnt2),
        .wr_cnt (wr_cnt2)
    );

    sram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'hbfc00000), .READ_LAT(3)) u_lat3 (
        .clk    (clk),
        .reset  (rst3),
        .bus    (bus3),
        .rd_cnt (rd_cnt3),
        .wr_cnt (wr_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive1(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus1.sram_en    = en;
        bus1.sram_wen   = wen;
        bus1.sram_addr  = addr;
        bus1.sram_wdata = wdata;
    endtask

    task automatic drive2(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus2.sram_en    = en;
        bus2.sram_wen   = wen;
        bus2.sram_addr  = addr;
        bus2.sram_wdata = wdata;
    endtask

    task automatic drive3(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus3.sram_en    = en;
        bus3.sram_wen   = wen;
        bus3.sram_addr  = addr;
        bus3.sram_wdata = wdata;
    endtask

    // Word 0 of the LAT1 instance is loaded before its reset; RAM survives reset.
    task automatic preload;
        drive1(1'b1, 4'hf, 32'hbfc00000, 32'hcafef00d);
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (bus1.sram_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_rdata: got %h want %h", bus1.sram_rdata, 32'h0); end
        checks++; if (bus1.rd_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rd_valid: got %b want 0", bus1.rd_valid); end
        checks++; if (bus1.addr_err !== 1'b0) begin errors++;
            $display("FAIL reset_addr_err: got %b want 0", bus1.addr_err); end
        checks++; if (rd_cnt1 !== 32'h0) begin errors++;
            $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt1); end
        checks++; if (wr_cnt1 !== 32'h0) begin errors++;
            $display("FAIL reset_wr_cnt: got %h want 0", wr_cnt1); end
        checks++; if (bus3.rd_valid !== 1'b0 || bus3.sram_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_lat3: got valid=%b rdata=%h want 0/0",
                     bus3.rd_valid, bus3.sram_rdata); end
    endtask

    task automatic test_read_hold;
        drive1(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus1.rd_valid !== 1'b1) begin errors++;
            $display("FAIL read1_valid: got %b want 1", bus1.rd_valid); end
        checks++; if (bus1.sram_rdata !== 32'hcafef00d) begin errors++;
            $display("FAIL read1_rdata: got %h want %h", bus1.sram_rdata, 32'hcafef00d); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus1.rd_valid !== 1'b0 || bus1.sram_rdata !== 32'hcafef00d) begin
                errors++;
                $display("FAIL hold_idle%0d: got valid=%b rdata=%h want 0/%h", i,
                         bus1.rd_valid, bus1.sram_rdata, 32'hcafef00d);
            end
        end
        checks++; if (rd_cnt1 !== 32'd1) begin errors++;
            $display("FAIL hold_rd_cnt: got %h want 1", rd_cnt1); end
    endtask

    task automatic test_byte_lanes;
        drive1(1'b1, 4'hf, 32'hbfc00010, 32'h11223344);
        @(negedge clk);
        drive1(1'b1, 4'b0100, 32'hbfc00010, 32'haaaaaaaa);
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.sram_rdata !== 32'hcafef00d) begin
            errors++;
            $display("FAIL hold_write: got valid=%b rdata=%h want 0/%h",
                     bus1.rd_valid, bus1.sram_rdata, 32'hcafef00d);
        end
        @(negedge clk);
        drive1(1'b1, 4'h0, 32'hbfc00010, 32'h0);
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.sram_rdata !== 32'h11aa3344) begin
            errors++;
            $display("FAIL lanes_rdata: got valid=%b rdata=%h want 1/%h",
                     bus1.rd_valid, bus1.sram_rdata, 32'h11aa3344);
        end
        checks++; if (wr_cnt1 !== 32'd2) begin errors++;
            $display("FAIL lanes_wr_cnt: got %h want 2", wr_cnt1); end
    endtask

    task automatic test_out_of_window;
        // 0x00000000 aliases word 0 if the window check were missing.
        drive1(1'b1, 4'hf, 32'h00000000, 32'h55555555);
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus1.addr_err !== 1'b1) begin errors++;
            $display("FAIL oow_wr_err: got %b want 1", bus1.addr_err); end
        checks++; if (wr_cnt1 !== 32'd2) begin errors++;
            $display("FAIL oow_wr_cnt: got %h want 2", wr_cnt1); end
        @(negedge clk);
        checks++; if (bus1.addr_err !== 1'b0) begin errors++;
            $display("FAIL oow_err_pulse: got %b want 0", bus1.addr_err); end
        drive1(1'b1, 4'h0, 32'h80000000, 32'h0);
        @(negedge clk);
        drive1(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.sram_rdata !== 32'h0
                      || bus1.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oow_read: got valid=%b rdata=%h err=%b want 1/0/1",
                     bus1.rd_valid, bus1.sram_rdata, bus1.addr_err);
        end
        checks++; if (rd_cnt1 !== 32'd2) begin errors++;
            $display("FAIL oow_rd_cnt: got %h want 2", rd_cnt1); end
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus1.sram_rdata !== 32'hcafef00d || bus1.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL oow_ram_kept: got rdata=%h err=%b want %h/0",
                     bus1.sram_rdata, bus1.addr_err, 32'hcafef00d);
        end
        checks++; if (rd_cnt1 !== 32'd3) begin errors++;
            $display("FAIL oow_rd_cnt2: got %h want 3", rd_cnt1); end
    endtask

    task automatic test_back_to_back;
        drive3(1'b1, 4'hf, 32'hbfc00100, 32'ha0a0a0a0);
        @(negedge clk);
        drive3(1'b1, 4'hf, 32'hbfc00104, 32'hb1b1b1b1);
        @(negedge clk);
        drive3(1'b1, 4'hf, 32'hbfc00108, 32'hc2c2c2c2);
        @(negedge clk);
        drive3(1'b1, 4'h0, 32'hbfc00100, 32'h0);
        @(negedge clk);
        drive3(1'b1, 4'h0, 32'hbfc00104, 32'h0);
        checks++; if (bus3.rd_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_early1: got valid=%b want 0", bus3.rd_valid); end
        @(negedge clk);
        drive3(1'b1, 4'h0, 32'hbfc00108, 32'h0);
        checks++; if (bus3.rd_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_early2: got valid=%b want 0", bus3.rd_valid); end
        @(negedge clk);
        drive3(1'b1, 4'hf, 32'hbfc00100, 32'hdeadbeef);
        checks++; if (bus3.rd_valid !== 1'b1 || bus3.sram_rdata !== 32'ha0a0a0a0) begin
            errors++;
            $display("FAIL b2b_a: got valid=%b rdata=%h want 1/%h",
                     bus3.rd_valid, bus3.sram_rdata, 32'ha0a0a0a0);
        end
        @(negedge clk);
        drive3(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus3.rd_valid !== 1'b1 || bus3.sram_rdata !== 32'hb1b1b1b1) begin
            errors++;
            $display("FAIL b2b_b: got valid=%b rdata=%h want 1/%h",
                     bus3.rd_valid, bus3.sram_rdata, 32'hb1b1b1b1);
        end
        @(negedge clk);
        checks++; if (bus3.rd_valid !== 1'b1 || bus3.sram_rdata !== 32'hc2c2c2c2) begin
            errors++;
            $display("FAIL b2b_c: got valid=%b rdata=%h want 1/%h",
                     bus3.rd_valid, bus3.sram_rdata, 32'hc2c2c2c2);
        end
        drive3(1'b1, 4'h0, 32'hbfc00100, 32'h0);
        @(negedge clk);
        drive3(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus3.rd_valid !== 1'b0 || bus3.sram_rdata !== 32'hc2c2c2c2) begin
            errors++;
            $display("FAIL b2b_hold: got valid=%b rdata=%h want 0/%h",
                     bus3.rd_valid, bus3.sram_rdata, 32'hc2c2c2c2);
        end
        @(negedge clk);
        checks++; if (bus3.rd_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_lat: got valid=%b want 0", bus3.rd_valid); end
        @(negedge clk);
        checks++; if (bus3.rd_valid !== 1'b1 || bus3.sram_rdata !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL b2b_new_a: got valid=%b rdata=%h want 1/%h",
                     bus3.rd_valid, bus3.sram_rdata, 32'hdeadbeef);
        end
        checks++; if (rd_cnt3 !== 32'd4 || wr_cnt3 !== 32'd4) begin errors++;
            $display("FAIL b2b_cnt: got rd=%h wr=%h want 4/4", rd_cnt3, wr_cnt3); end
    endtask

    task automatic test_reset_midflight;
        drive2(1'b1, 4'hf, 32'hbfc00020, 32'h12345678);
        @(negedge clk);
        drive2(1'b1, 4'h0, 32'hbfc00020, 32'h0);
        @(negedge clk);
        drive2(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus2.rd_valid !== 1'b0) begin errors++;
            $display("FAIL lat2_early: got valid=%b want 0", bus2.rd_valid); end
        @(negedge clk);
        checks++; if (bus2.rd_valid !== 1'b1 || bus2.sram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL lat2_read: got valid=%b rdata=%h want 1/%h",
                     bus2.rd_valid, bus2.sram_rdata, 32'h12345678);
        end
        drive2(1'b1, 4'h0, 32'hbfc00020, 32'h0);
        @(negedge clk);
        // Write presented with reset must be dropped.
        drive2(1'b1, 4'hf, 32'hbfc00020, 32'hffffffff);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        drive2(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus2.rd_valid !== 1'b0 || bus2.sram_rdata !== 32'h0) begin errors++;
            $display("FAIL mid_reset_out: got valid=%b rdata=%h want 0/0",
                     bus2.rd_valid, bus2.sram_rdata); end
        checks++; if (rd_cnt2 !== 32'h0 || wr_cnt2 !== 32'h0) begin errors++;
            $display("FAIL mid_reset_cnt: got rd=%h wr=%h want 0/0", rd_cnt2, wr_cnt2); end
        @(negedge clk);
        checks++; if (bus2.rd_valid !== 1'b0) begin errors++;
            $display("FAIL mid_reset_late: got valid=%b want 0", bus2.rd_valid); end
        drive2(1'b1, 4'h0, 32'hbfc00020, 32'h0);
        @(negedge clk);
        drive2(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (bus2.rd_valid !== 1'b1 || bus2.sram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL reset_write_dropped: got valid=%b rdata=%h want 1/%h",
                     bus2.rd_valid, bus2.sram_rdata, 32'h12345678);
        end
        checks++; if (rd_cnt2 !== 32'd1 || wr_cnt2 !== 32'd0) begin errors++;
            $display("FAIL post_reset_cnt: got rd=%h wr=%h want 1/0", rd_cnt2, wr_cnt2); end
    endtask

    task automatic test_saturation;
        force u_lat1.rd_cnt_q = 32'hfffffffe;
        #1;
        release u_lat1.rd_cnt_q;
        checks++; if (rd_cnt1 !== 32'hfffffffe) begin errors++;
            $display("FAIL sat_preset: got %h want %h", rd_cnt1, 32'hfffffffe); end
        @(negedge clk);
        drive1(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        @(negedge clk);
        checks++; if (rd_cnt1 !== 32'hffffffff) begin errors++;
            $display("FAIL sat_read1: got %h want %h", rd_cnt1, 32'hffffffff); end
        @(negedge clk);
        checks++; if (rd_cnt1 !== 32'hffffffff) begin errors++;
            $display("FAIL sat_read2: got %h want %h", rd_cnt1, 32'hffffffff); end
        @(negedge clk);
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (rd_cnt1 !== 32'hffffffff) begin errors++;
            $display("FAIL sat_read3: got %h want %h", rd_cnt1, 32'hffffffff); end
        checks++; if (wr_cnt1 !== 32'd2) begin errors++;
            $display("FAIL sat_wr_cnt: got %h want 2", wr_cnt1); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        rst3 = 1'b1;
        drive1(1'b0, 4'h0, 32'h0, 32'h0);
        drive2(1'b0, 4'h0, 32'h0, 32'h0);
        drive3(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        rst2 = 1'b0;
        rst3 = 1'b0;
        preload();
        test_reset();
        test_read_hold();
        test_byte_lanes();
        test_out_of_window();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
